// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/LSU memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STREAK_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational grant selection: LSU priority with a streak guard for a waiting IFU.
module arb_prio_sel (
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic streak_sat,
  output logic grant_ifu,
  output logic grant_lsu
);

  // Once the LSU streak saturates, a waiting IFU takes the next grant.
  assign grant_lsu = lsu_valid & ~(streak_sat & ifu_valid);
  assign grant_ifu = ifu_valid & ~grant_lsu;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU: one transaction in flight,
// registered responses, LSU priority with anti-starvation and a response timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STREAK_MAX = STREAK_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic                lsu_resp_err,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int MASK_W   = DATA_W / 8;
  localparam int STREAK_W = $clog2(STREAK_MAX + 1);
  localparam int TMR_W    = $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ifu_rv_q, ifu_rv_d, lsu_rv_q, lsu_rv_d;
  logic                ifu_err_q, ifu_err_d, lsu_err_q, lsu_err_d;
  logic                grant_ifu, grant_lsu, idle, tmo_hit, done, abort;

  assign idle = (state_q == ARB_IDLE);

  arb_prio_sel u_prio_sel (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .streak_sat (streak_q == STREAK_W'(STREAK_MAX)),
    .grant_ifu  (grant_ifu),
    .grant_lsu  (grant_lsu)
  );

  assign ifu_req_ready = idle & ~reset & grant_ifu;
  assign lsu_req_ready = idle & ~reset & grant_lsu;

  // timer_q trails the busy-cycle count by one and the pulse is registered,
  // so this places the error pulse exactly TIMEOUT cycles after the grant.
  assign tmo_hit = (timer_q == TMR_W'(TIMEOUT - 2));
  assign done    = (state_q == ARB_RESP) & mem_resp_valid;
  assign abort   = ~idle & ~done & tmo_hit;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    streak_d  = streak_q;
    timer_d   = timer_q;
    rdata_d   = rdata_q;
    ifu_rv_d  = 1'b0;
    lsu_rv_d  = 1'b0;
    ifu_err_d = 1'b0;
    lsu_err_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (lsu_req_ready) begin
          state_d = ARB_REQ;
          owner_d = OWN_LSU;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          timer_d = '0;
          if (!ifu_req_valid)                         streak_d = '0;
          else if (streak_q != STREAK_W'(STREAK_MAX)) streak_d = streak_q + 1'b1;
        end else if (ifu_req_ready) begin
          state_d  = ARB_REQ;
          owner_d  = OWN_IFU;
          addr_d   = ifu_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          timer_d  = '0;
          streak_d = '0;
        end
      end
      ARB_REQ: begin
        timer_d = timer_q + 1'b1;
        if (mem_req_ready) state_d = ARB_RESP;
      end
      ARB_RESP: timer_d = timer_q + 1'b1;
      default:  state_d = ARB_IDLE;
    endcase

    // A real response beats a timeout that matures in the same cycle.
    if (done || abort) begin
      state_d = ARB_IDLE;
      rdata_d = done ? mem_rdata : '0;
      if (owner_q == OWN_LSU) begin
        lsu_rv_d  = 1'b1;
        lsu_err_d = abort;
      end else begin
        ifu_rv_d  = 1'b1;
        ifu_err_d = abort;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_IFU;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      streak_q  <= '0;
      timer_q   <= '0;
      rdata_q   <= '0;
      ifu_rv_q  <= 1'b0;
      lsu_rv_q  <= 1'b0;
      ifu_err_q <= 1'b0;
      lsu_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      streak_q  <= streak_d;
      timer_q   <= timer_d;
      rdata_q   <= rdata_d;
      ifu_rv_q  <= ifu_rv_d;
      lsu_rv_q  <= lsu_rv_d;
      ifu_err_q <= ifu_err_d;
      lsu_err_q <= lsu_err_d;
    end
  end

  assign mem_req_valid  = (state_q == ARB_REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign resp_rdata     = rdata_q;
  assign ifu_resp_valid = ifu_rv_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign ifu_resp_err   = ifu_err_q;
  assign lsu_resp_err   = lsu_err_q;
  assign busy           = ~idle;
  assign owner          = owner_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single physical memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the RV32I core.
- Accepts one transaction at a time and holds it on the memory side until the memory accepts it.
- Waits for the memory response and returns it, registered, to the owning requester.
- LSU has priority over IFU, with an anti-starvation streak guard, plus a response timeout that reports an error.
- Sits between the core's fetch and load/store logic and the memory bus (DPI or SoC bus bridge).

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STREAK_MAX, 4, consecutive LSU grants allowed while IFU is waiting before IFU is forced
TIMEOUT, 255, cycles spent in ARB_REQ+ARB_RESP before a transaction is aborted with error

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ifu_req_valid  in  1  IFU request valid (read only)
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  IFU fetch address
ifu_resp_valid  out  1  one-cycle pulse, IFU response
ifu_resp_err  out  1  IFU response is a timeout error
lsu_req_valid  in  1  LSU request valid
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1 = store
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  store byte mask
lsu_resp_valid  out  1  one-cycle pulse, LSU response
lsu_resp_err  out  1  LSU response is a timeout error
resp_rdata  out  DATA_W  registered read data, shared by both requesters, qualified by *_resp_valid
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable (0 for IFU)
mem_wdata  out  DATA_W  latched store data
mem_wmask  out  DATA_W/8  latched mask (0 for IFU)
mem_resp_valid  in  1  memory response; also acknowledges writes
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != ARB_IDLE
owner  out  1  0 = IFU, 1 = LSU; current/last grant

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to ARB_IDLE.
  - All outputs and registers go to 0, and the streak counter and timeout counter clear.
  - Any in-flight transaction is dropped with no response pulse.
- ARB_IDLE:
  - The grant is selected combinationally from the request valids.
  - LSU wins if lsu_req_valid, unless streak == STREAK_MAX and ifu_req_valid, in which case IFU wins.
  - If only IFU is valid, IFU wins.
  - The granted *_req_ready is asserted combinationally in the same cycle; the other ready stays 0. Both readies are 0 outside ARB_IDLE.
  - On a grant, latch addr/wen/wdata/wmask and owner, then go to ARB_REQ. For an IFU grant, wen and wmask are latched as 0.
- Streak counter:
  - LSU grant while ifu_req_valid: +1, saturating at STREAK_MAX.
  - IFU grant: reset to 0.
  - LSU grant without IFU waiting: reset to 0.
- ARB_REQ:
  - mem_req_valid = 1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready, go to ARB_RESP. mem_resp_valid is ignored in this state.
- ARB_RESP:
  - On mem_resp_valid, register mem_rdata into resp_rdata and pulse the owner's resp_valid for exactly one cycle (the next cycle). resp_err = 0.
  - resp_rdata is updated for writes too.
  - Return to ARB_IDLE. A new grant is possible in the same cycle as the resp_valid pulse.
- Minimum latency:
  - Grant at cycle 0, request handshake at cycle 1, memory response at cycle 2, resp_valid at cycle 3. That is 3 cycles from grant to response.
- Timeout:
  - The counter clears on grant and increments every cycle in ARB_REQ/ARB_RESP.
  - When it reaches TIMEOUT without completion, pulse the owner's resp_valid with resp_err = 1 and resp_rdata = 0, deassert mem_req_valid, and return to ARB_IDLE.
  - A late mem_resp_valid arriving in ARB_IDLE is ignored.
  - Timeout and mem_resp_valid in the same cycle: the response wins, err = 0.
- Simultaneous events:
  - Requesters must hold valid and fields stable until ready.
  - Fields are latched at grant, so upstream changes after the grant are ignored.
  - At most one resp_valid is asserted per cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_REQ, ARB_RESP};
  - typedef enum logic owner_t {OWN_IFU = 0, OWN_LSU = 1};
  - shared localparams for the default widths.
- One sub-module, arb_prio_sel:
  - Combinational grant selection from the two valids and the streak-saturated flag.
  - Outputs grant_ifu and grant_lsu.
- The top holds the FSM, the latches and the counters.

Test Plan:
1. IFU-only read: ifu_req_valid with addr 0x80000000, mem_req_ready = 1 immediately, mem_resp_valid the next cycle with rdata 0x00100073 -> ifu_resp_valid pulses once at grant+3, resp_rdata = 0x00100073, err = 0.
2. Simultaneous requests: LSU sw to 0x80001000, data 0xDEADBEEF, wmask 0xF; IFU waiting -> LSU granted first with mem_wen = 1 and mem_wmask = 0xF; IFU granted immediately after LSU's response; owner sequence 1, 0.
3. Starvation guard with STREAK_MAX = 4: LSU valid continuously and IFU valid continuously -> exactly 4 LSU grants, then an IFU grant, then LSU again.
4. Back-pressure: mem_req_ready held 0 for 10 cycles -> mem_req_valid and mem_addr stay stable for 10 cycles and both req_ready stay 0; completion is normal after ready.
5. Timeout with TIMEOUT = 8: no mem_resp_valid -> lsu_resp_valid with err = 1 and rdata = 0 at grant+8; a late mem_resp_valid is ignored; busy = 0.
6. Reset asserted asynchronously mid ARB_RESP -> all outputs 0 immediately without a clock edge, no resp pulse, next request behaves as in scenario 1.
